// File: rtl/rv_mem_arbiter.sv
// Single-port memory arbiter sharing one 1-cycle-latency memory between the
// instruction fetch port and the load/store unit, with fetch-stall accounting.
module rv_mem_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-1:0] im_addr_i,
    output logic [31:0]           im_data_o,
    output logic                  im_valid_o,
    input  logic [ADDR_WIDTH-1:0] dm_addr_i,
    input  logic [31:0]           dm_data_s_i,
    input  logic [3:0]            dm_data_select_i,
    input  logic                  dm_load_i,
    input  logic                  dm_store_i,
    output logic [31:0]           dm_data_l_o,
    output logic                  dm_load_done_o,
    output logic                  dm_store_done_o,
    output logic                  dm_misaligned_o,
    output logic [ADDR_WIDTH-3:0] mem_addr_o,
    output logic [31:0]           mem_wdata_o,
    output logic [3:0]            mem_we_o,
    input  logic [31:0]           mem_rdata_i,
    output logic [31:0]           stall_cnt_o
);

    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        GNT_NONE  = 2'd0,
        GNT_FETCH = 2'd1,
        GNT_LOAD  = 2'd2,
        GNT_STORE = 2'd3
    } grant_t;

    grant_t         own_q;
    grant_t         grant;
    logic           mis_q;
    logic           mis_d;
    logic [SW-1:0]  starve_q;
    logic [31:0]    stall_q;
    logic           data_req;
    logic           data_elig;
    logic           starved;
    logic           unused_im_lsb;

    assign unused_im_lsb = ^im_addr_i[1:0];

    function automatic logic is_misaligned(input logic [3:0] sel, input logic [1:0] a);
        logic bad;
        case (sel)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: bad = 1'b0;
            4'b0011, 4'b1100:                   bad = a[0];
            4'b1111:                            bad = |a;
            default:                            bad = 1'b1;
        endcase
        return bad;
    endfunction

    // State register: last grant, pending misalignment report, counters
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            own_q    <= GNT_NONE;
            mis_q    <= 1'b0;
            starve_q <= '0;
            stall_q  <= '0;
        end else begin
            own_q <= grant;
            mis_q <= mis_d;
            if (grant == GNT_FETCH) begin
                starve_q <= '0;
            end else if ((grant == GNT_LOAD || grant == GNT_STORE) && starve_q != STARVE_MAX) begin
                starve_q <= starve_q + 1'b1;
            end
            if (grant != GNT_FETCH) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end

    // A request whose completion is reported this cycle must not be granted again
    always_comb begin
        grant     = GNT_FETCH;
        mis_d     = 1'b0;
        data_req  = dm_load_i | dm_store_i;
        data_elig = (own_q != GNT_LOAD) && (own_q != GNT_STORE) && !mis_q;
        starved   = (starve_q == STARVE_MAX);
        if (data_req && data_elig && !starved) begin
            if (is_misaligned(dm_data_select_i, dm_addr_i[1:0])) begin
                grant = GNT_NONE;
                mis_d = 1'b1;
            end else if (dm_store_i) begin
                grant = GNT_STORE;
            end else begin
                grant = GNT_LOAD;
            end
        end
    end

    always_comb begin
        mem_addr_o  = im_addr_i[ADDR_WIDTH-1:2];
        mem_wdata_o = dm_data_s_i;
        mem_we_o    = 4'b0000;
        case (grant)
            GNT_LOAD: begin
                mem_addr_o = dm_addr_i[ADDR_WIDTH-1:2];
            end
            GNT_STORE: begin
                mem_addr_o = dm_addr_i[ADDR_WIDTH-1:2];
                mem_we_o   = dm_data_select_i;
            end
            default: begin
            end
        endcase
        if (rst_i) begin
            mem_we_o = 4'b0000;
        end
    end

    assign im_valid_o      = (own_q == GNT_FETCH);
    assign dm_load_done_o  = (own_q == GNT_LOAD);
    assign dm_store_done_o = (own_q == GNT_STORE);
    assign dm_misaligned_o = mis_q;
    assign im_data_o       = mem_rdata_i;
    assign dm_data_l_o     = mem_rdata_i;
    assign stall_cnt_o     = stall_q;

endmodule
